// File: rtl/matrix_key_scan.sv
// rtl/matrix_key_scan.sv - 4x4 key matrix scanner with per-scan debounce and press strobe
module matrix_key_scan #(
    parameter int SCAN_DIV       = 1024,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic [15:0] key_map_o,
    output logic        key_down_o,
    output logic [3:0]  key_code_o,
    output logic        key_valid_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int MC_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [MC_W-1:0]  MATCH_FULL = MC_W'(DEBOUNCE_SCANS);

    logic [3:0]       row_meta_q, row_sync_q;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       col_q;
    logic [15:0]      scan_q, scan_d;
    logic [15:0]      prev_q, prev_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [15:0]      key_map_q, key_map_d;
    logic [15:0]      old_map_q;
    logic             key_down_q;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic [15:0]      scan_full;
    logic [15:0]      new_keys;
    logic [3:0]       low_idx;

    always_comb begin
        col_idx_d = col_idx_q;
        div_cnt_d = div_cnt_q + DIV_W'(1);
        scan_d    = scan_q;
        prev_d    = prev_q;
        match_d   = match_q;
        key_map_d = key_map_q;
        scan_full = scan_q;
        scan_full[col_idx_q*4 +: 4] = ~row_sync_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            col_idx_d = col_idx_q + 2'd1;
            scan_d    = scan_full;
            // Column 3 closes a full scan: run the debounce on the completed map.
            if (col_idx_q == 2'd3) begin
                prev_d = scan_full;
                if (scan_full == prev_q) begin
                    match_d = (match_q == MATCH_FULL) ? match_q : match_q + MC_W'(1);
                end else begin
                    match_d = MC_W'(1);
                end
                if (match_d == MATCH_FULL && scan_full != key_map_q) begin
                    key_map_d = scan_full;
                end
            end
        end
    end

    // Only newly set bits strobe; releases never do.
    always_comb begin
        new_keys = key_map_q & ~old_map_q;
        low_idx  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (new_keys[i]) begin
                low_idx = 4'(i);
            end
        end
        key_valid_d = |new_keys;
        key_code_d  = key_valid_d ? low_idx : key_code_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            col_idx_q   <= 2'd0;
            div_cnt_q   <= '0;
            col_q       <= 4'b1111;
            scan_q      <= '0;
            prev_q      <= '0;
            match_q     <= '0;
            key_map_q   <= '0;
            old_map_q   <= '0;
            key_down_q  <= 1'b0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            row_meta_q  <= row_i;
            row_sync_q  <= row_meta_q;
            col_idx_q   <= col_idx_d;
            div_cnt_q   <= div_cnt_d;
            col_q       <= ~(4'b0001 << col_idx_q);
            scan_q      <= scan_d;
            prev_q      <= prev_d;
            match_q     <= match_d;
            key_map_q   <= key_map_d;
            old_map_q   <= key_map_q;
            key_down_q  <= |key_map_q;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_o       = col_q;
    assign key_map_o   = key_map_q;
    assign key_down_o  = key_down_q;
    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
// tb/tb_matrix_key_scan.sv - scoreboard bench for matrix_key_scan with a per-scan key matrix model
module tb_matrix_key_scan;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] key_map;
    logic        key_down;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] pressed;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    logic [15:0] adopted, last_map, cur_stim;
    int          run;
    bit          scan_pending;

    matrix_key_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(D)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .row_i      (row),
        .col_o      (col),
        .key_map_o  (key_map),
        .key_down_o (key_down),
        .key_code_o (key_code),
        .key_valid_o(key_valid)
    );

    always #5 clk = ~clk;

    // A row reads low when a pressed key joins it to the one column driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_key_valid actual_code=%0d expected=no strobe", key_code);
            end else begin
                check("key_code", key_code, exp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        adopted      = '0;
        last_map     = '0;
        run          = 0;
        scan_pending = 0;
    endtask

    // Adopt a map once the last D completed scans were identical.
    task automatic model_scan(input logic [15:0] m);
        logic [15:0] nb;
        bit          found;
        if (run > 0 && m == last_map) run++;
        else run = 1;
        last_map = m;
        if (run >= D && m != adopted) begin
            nb    = m & ~adopted;
            found = 0;
            for (int i = 0; i < 16; i++) begin
                if (nb[i] && !found) begin
                    exp_q.push_back(i);
                    found = 1;
                end
            end
            adopted = m;
        end
    endtask

    task automatic wait_col0();
        logic [3:0] prev_c, cur_c;
        bit         seen;
        cur_c = col;
        seen  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            prev_c = cur_c;
            cur_c  = col;
            if (cur_c == 4'b1110 && prev_c != 4'b1110) seen = 1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL col0_timeout actual_col=%b expected=1110 within 40 clocks", col);
        end
    endtask

    task automatic apply_scan(input logic [15:0] m);
        wait_col0();
        if (scan_pending) begin
            model_scan(cur_stim);
            check("key_map", key_map, adopted);
        end
        cur_stim     = m;
        pressed      = m;
        scan_pending = 1;
        @(negedge clk);
        check("key_down", key_down, adopted != 0);
    endtask

    task automatic hold(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) apply_scan(m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        logic [3:0]  walk [4];
        logic [15:0] m;
        walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011; walk[3] = 4'b0111;
        rst     = 1'b1;
        pressed = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_col", col, 4'b1111);
        check("rst_key_map", key_map, 16'h0);
        check("rst_key_down", key_down, 1'b0);
        check("rst_key_code", key_code, 4'd0);
        check("rst_key_valid", key_valid, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check("col_walk", col, walk[(k/4)%4]);
        end

        hold(16'h0000, 3);
        hold(16'h0200, 12);
        hold(16'h0000, 3);
        for (int i = 0; i < 6; i++) apply_scan((i % 2 == 0) ? 16'h0020 : 16'h0000);
        hold(16'h0020, 3);
        hold(16'h0000, 3);
        hold(16'h1008, 3);
        hold(16'h1088, 3);
        hold(16'h0000, 3);
        hold(16'h0200, 3);

        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_col", col, 4'b1111);
        check("midrst_key_map", key_map, 16'h0);
        check("midrst_key_down", key_down, 1'b0);
        check("midrst_key_code", key_code, 4'd0);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_pending_strobes", exp_q.size(), 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(16'h0200, 4);

        m = 16'h0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(9) >= 6) m = 16'($urandom & $urandom & $urandom);
            apply_scan(m);
        end
        hold(16'h0000, 3);
        repeat (4) @(negedge clk);
        check("strobes_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
